// File: rtl/nbr_color_checker.sv
// Neighbour colour checker: walks a vertex's adjacency list over the shared memory port
// and reports whether the candidate colour clashes. Define NBR_COLOR_COMMIT_EN to write the colour back on success.
module nbr_color_checker #(
  parameter logic [7:0]  ADJ_BASE   = 8'd0,
  parameter logic [7:0]  OFF_BASE   = 8'd148,
  parameter logic [7:0]  COLOR_BASE = 8'd182,
  parameter int unsigned NODES      = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] node,
  input  logic [7:0] color,
  output logic       busy,
  output logic       done,
  output logic       conflict,
  output logic [7:0] conflict_node,
  output logic       err,
  output logic       mem_req,
  input  logic       mem_gnt,
  output logic [7:0] mem_addr,
  output logic       mem_we,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE, REQ, OFF0, OFF1, ADJ, COL, DONE
`ifdef NBR_COLOR_COMMIT_EN
    , COMMIT
`endif
  } state_t;

  localparam logic [7:0] NodesW = 8'(NODES);

`ifdef NBR_COLOR_COMMIT_EN
  localparam state_t AfterWalk = COMMIT;
`else
  localparam state_t AfterWalk = DONE;
`endif

  state_t     state_q, state_d;
  logic [7:0] node_q, node_d;
  logic [7:0] color_q, color_d;
  logic [7:0] ptr_q, ptr_d;
  logic [7:0] hi_q, hi_d;
  logic [7:0] nbr_q, nbr_d;
  logic       conflict_q, conflict_d;
  logic [7:0] cnode_q, cnode_d;
  logic       err_q, err_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      node_q     <= '0;
      color_q    <= '0;
      ptr_q      <= '0;
      hi_q       <= '0;
      nbr_q      <= '0;
      conflict_q <= 1'b0;
      cnode_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      node_q     <= node_d;
      color_q    <= color_d;
      ptr_q      <= ptr_d;
      hi_q       <= hi_d;
      nbr_q      <= nbr_d;
      conflict_q <= conflict_d;
      cnode_q    <= cnode_d;
      err_q      <= err_d;
    end
  end

  // Every memory-phase state only advances and updates registers when the grant is present.
  always_comb begin
    state_d    = state_q;
    node_d     = node_q;
    color_d    = color_q;
    ptr_d      = ptr_q;
    hi_d       = hi_q;
    nbr_d      = nbr_q;
    conflict_d = conflict_q;
    cnode_d    = cnode_q;
    err_d      = err_q;
    mem_req    = 1'b0;
    mem_addr   = '0;
    mem_we     = 1'b0;
    mem_wdata  = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          node_d     = node;
          color_d    = color;
          conflict_d = 1'b0;
          cnode_d    = '0;
          err_d      = 1'b0;
          if (node >= NodesW || color == 8'd0 || color > 8'd4) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        mem_req = 1'b1;
        if (mem_gnt) state_d = OFF0;
      end
      OFF0: begin
        mem_req  = 1'b1;
        mem_addr = OFF_BASE + node_q;
        if (mem_gnt) begin
          ptr_d   = mem_rdata;
          state_d = OFF1;
        end
      end
      OFF1: begin
        mem_req  = 1'b1;
        mem_addr = OFF_BASE + node_q + 8'd1;
        if (mem_gnt) begin
          hi_d = mem_rdata;
          // ptr still holds the window start here, so it doubles as lo.
          if (mem_rdata < ptr_q || mem_rdata > OFF_BASE) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else if (mem_rdata == ptr_q) begin
            state_d = AfterWalk;
          end else begin
            state_d = ADJ;
          end
        end
      end
      ADJ: begin
        mem_req  = 1'b1;
        mem_addr = ADJ_BASE + ptr_q;
        if (mem_gnt) begin
          nbr_d   = mem_rdata;
          state_d = COL;
        end
      end
      COL: begin
        mem_req  = 1'b1;
        mem_addr = COLOR_BASE + nbr_q;
        if (mem_gnt) begin
          if (mem_rdata == color_q) begin
            conflict_d = 1'b1;
            cnode_d    = nbr_q;
            state_d    = DONE;
          end else begin
            ptr_d   = ptr_q + 8'd1;
            state_d = (ptr_q + 8'd1 < hi_q) ? ADJ : AfterWalk;
          end
        end
      end
`ifdef NBR_COLOR_COMMIT_EN
      COMMIT: begin
        mem_req   = 1'b1;
        mem_addr  = COLOR_BASE + node_q;
        mem_wdata = color_q;
        mem_we    = mem_gnt;
        if (mem_gnt) state_d = DONE;
      end
`endif
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign conflict      = conflict_q;
  assign conflict_node = cnode_q;
  assign err           = err_q;

endmodule
